// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response pair, and the
// in-order instruction output stream with occupancy and error status.
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_rvalid;
  logic [DATA_W-1:0] im_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [CNT_W-1:0]  count;
  logic              err;

  modport master (
    input  redirect_valid, redirect_pc, im_rvalid, im_rdata, out_ready,
    output im_req, im_addr, out_valid, out_pc, out_instr, count, err
  );

  modport slave (
    output redirect_valid, redirect_pc, im_rvalid, im_rdata, out_ready,
    input  im_req, im_addr, out_valid, out_pc, out_instr, count, err
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: reserve a slot per request, fill on response, pop to consumer.
// Latency >= 2 cycles request-to-output; out_ready low stalls the head and requests stop once all slots are reserved.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000)
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int PW     = $clog2(DEPTH);
  localparam int PTR_W  = PW + 1;
  localparam int CNT_W  = PW + 1;
  localparam int DROP_W = PW + 4;

  // Pointers carry a wrap bit so head==fill is unambiguous when every slot is filled.
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] slot_pc_q    [DEPTH];
  logic [DATA_W-1:0] slot_instr_q [DEPTH];

  logic [CNT_W-1:0] count_w;
  logic [PTR_W-1:0] pend_w;
  logic             reserve;
  logic             pop;
  logic             rsp_owed;
  logic             rsp_orphan;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             slot_fill;
  logic             out_valid_w;

  assign count_w     = CNT_W'(tail_q - head_q);
  assign pend_w      = tail_q - fill_q;
  assign out_valid_w = (head_q != fill_q);

  assign reserve    = reset && !bus.redirect_valid && (count_w < CNT_W'(DEPTH));
  assign pop        = out_valid_w && bus.out_ready && !bus.redirect_valid;
  assign rsp_owed   = bus.im_rvalid && ((pend_w != '0) || (drop_q != '0));
  assign rsp_orphan = bus.im_rvalid && (pend_w == '0) && (drop_q == '0);
  assign rsp_drop   = bus.im_rvalid && (drop_q != '0);
  assign rsp_fill   = bus.im_rvalid && (drop_q == '0) && (pend_w != '0);
  assign slot_fill  = reset && !bus.redirect_valid && rsp_fill;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    err_d      = err_q | rsp_orphan;
    if (bus.redirect_valid) begin
      // Every reserved-but-unfilled slot still has a response in flight that must be skipped.
      fetch_pc_d = bus.redirect_pc;
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      drop_d     = DROP_W'(pend_w) + drop_q - DROP_W'(rsp_owed);
    end else begin
      if (reserve) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (rsp_drop) drop_d = drop_q - DROP_W'(1);
      if (rsp_fill) fill_d = fill_q + PTR_W'(1);
      if (pop)      head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reserve)   slot_pc_q[tail_q[PW-1:0]]    <= fetch_pc_q;
    if (slot_fill) slot_instr_q[fill_q[PW-1:0]] <= bus.im_rdata;
  end

  assign bus.im_req    = reserve;
  assign bus.im_addr   = fetch_pc_q;
  assign bus.out_valid = out_valid_w;
  assign bus.out_pc    = slot_pc_q[head_q[PW-1:0]];
  assign bus.out_instr = slot_instr_q[head_q[PW-1:0]];
  assign bus.count     = count_w;
  assign bus.err       = err_q;
endmodule
